// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered 8-bit arithmetic/logic unit, one-stage pipeline slice.
//
// Every rising edge of clk samples a, b, op and c_in and registers the
// result together with the carry-out, a carry flag and a zero flag. A new
// operation is accepted every cycle; there is no handshake.
//
// Ports
//   clk     in   1  clock, rising edge
//   rst     in   1  asynchronous, active-high reset
//   a       in   8  operand A (unsigned)
//   b       in   8  operand B (unsigned, ignored by shifts)
//   op      in   3  opcode: ADD SUB AND OR XOR XNOR SHL SHR
//   c_in    in   1  carry-in (ADD/SUB) or shift-in bit (SHL/SHR)
//   out     out  8  registered result
//   c_out   out  1  registered carry / shifted-out bit
//   c_flag  out  1  registered carry flag
//   zero    out  1  registered flag, 1 when out == 0
//
// Build option
//   ALU_FLAG_HOLD_EN  defined:   c_flag loads only on ADD/SUB/SHL/SHR and
//                                holds across the logic ops.
//                     undefined: c_flag is a plain copy of c_out.
// ---------------------------------------------------------------------------
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  input  logic       c_in,
  output logic [7:0] out,
  output logic       c_out,
  output logic       c_flag,
  output logic       zero
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_SHL  = 3'b110,
    OP_SHR  = 3'b111
  } op_e;

  op_e        w_op;
  logic [7:0] w_b_opnd;
  logic [8:0] w_sum;
  logic [7:0] w_res;
  logic       w_c;

  logic [7:0] r_out;
  logic       r_c_out;
  logic       r_c_flag;
  logic       r_zero;

  assign w_op = op_e'(op);

  // One shared adder serves ADD and SUB; SUB feeds ~b so that c_in=1 gives
  // a true two's-complement subtract and the carry reads as "no borrow".
  assign w_b_opnd = (w_op == OP_SUB) ? ~b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_b_opnd} + {8'h00, c_in};

  always_comb begin
    w_res = 8'h00;
    w_c   = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum[7:0];
        w_c   = w_sum[8];
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_XNOR: w_res = ~(a ^ b);
      OP_SHL: begin
        w_res = {a[6:0], c_in};
        w_c   = a[7];
      end
      OP_SHR: begin
        w_res = {c_in, a[7:1]};
        w_c   = a[0];
      end
      default: begin
        w_res = 8'h00;
        w_c   = 1'b0;
      end
    endcase
  end

`ifdef ALU_FLAG_HOLD_EN
  // Only the carry-producing ops may touch the flag.
  logic w_flag_upd;
  assign w_flag_upd = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                      (w_op == OP_SHL) || (w_op == OP_SHR);
`endif

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out    <= 8'h00;
      r_c_out  <= 1'b0;
      r_c_flag <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_out   <= w_res;
      r_c_out <= w_c;
      r_zero  <= (w_res == 8'h00);
`ifdef ALU_FLAG_HOLD_EN
      if (w_flag_upd) begin
        r_c_flag <= w_c;
      end
`else
      r_c_flag <= w_c;
`endif
    end
  end

  assign out    = r_out;
  assign c_out  = r_c_out;
  assign c_flag = r_c_flag;
  assign zero   = r_zero;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu. Expected results are pushed to a
// scoreboard queue when an operation is driven and popped after the edge
// that registers it.
// ---------------------------------------------------------------------------
module tb_alu;

`ifdef ALU_FLAG_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       c_in;
  logic [7:0] out;
  logic       c_out;
  logic       c_flag;
  logic       zero;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .op     (op),
    .c_in   (c_in),
    .out    (out),
    .c_out  (c_out),
    .c_flag (c_flag),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed expectation: {out[7:0], c_out, c_flag, zero}
  typedef struct {
    logic [10:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_asrt = 0;
  int   n_fail = 0;
  logic m_cflag = 1'b0;

  // Reference: plain integer arithmetic, returns {carry, result}.
  function automatic logic [8:0] ref_op(input logic [7:0] ia, input logic [7:0] ib,
                                        input logic [2:0] iop, input logic ic);
    int s;
    int r;
    int c;
    s = 0; r = 0; c = 0;
    case (iop)
      3'd0: begin s = int'(ia) + int'(ib) + int'(ic);         r = s % 256; c = s / 256; end
      3'd1: begin s = int'(ia) + (255 - int'(ib)) + int'(ic); r = s % 256; c = s / 256; end
      3'd2: r = int'(ia & ib);
      3'd3: r = int'(ia | ib);
      3'd4: r = int'(ia ^ ib);
      3'd5: r = 255 - int'(ia ^ ib);
      3'd6: begin r = (int'(ia) * 2 + int'(ic)) % 256; c = int'(ia) / 128; end
      default: begin r = int'(ia) / 2 + int'(ic) * 128; c = int'(ia) % 2; end
    endcase
    return {c[0], r[7:0]};
  endfunction

  // Drive one op at the falling edge, push its expectation, and return
  // #1 after the rising edge that registers it.
  task automatic push_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] top,
                         input logic tc, input bit use_const, input logic [10:0] ev,
                         input string nm);
    logic [8:0] m;
    exp_t       e;
    @(negedge clk);
    a = ta; b = tb_v; op = top; c_in = tc;
    m = ref_op(ta, tb_v, top, tc);
    if (!(HOLD && top >= 3'd2 && top <= 3'd5)) m_cflag = m[8];
    e.nm = nm;
    e.v  = use_const ? ev : {m[7:0], m[8], m_cflag, (m[7:0] == 8'h00)};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    // power-up reset
    rst = 1'b1; a = 8'h00; b = 8'h00; op = 3'd0; c_in = 1'b0;
    #1;
    n_asrt++;
    if ({out, c_out, c_flag, zero} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_initial: got %h/%b/%b/%b want 00/0/0/1", out, c_out, c_flag, zero);
    end
    @(negedge clk); rst = 1'b0;
    push_op(8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0, 11'h0, "pre_reset_add");
    begin
      exp_t e;
      e = sb.pop_front();
      n_asrt++;
      if ({out, c_out, c_flag, zero} !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h/%b/%b/%b want %h/%b/%b/%b", e.nm, out, c_out, c_flag, zero,
                 e.v[10:3], e.v[2], e.v[1], e.v[0]);
      end
    end
    // mid-cycle assertion must clear outputs without waiting for an edge
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_asrt++;
    if ({out, c_out, c_flag, zero} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_async: got %h/%b/%b/%b want 00/0/0/1", out, c_out, c_flag, zero);
    end
    sb.delete();
    m_cflag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); a = 8'hFF; b = 8'h01; op = 3'd0; c_in = 1'b1;
      @(posedge clk); #1;
      n_asrt++;
      if ({out, c_out, c_flag, zero} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_hold%0d: got %h/%b/%b/%b want 00/0/0/1", i, out, c_out, c_flag, zero);
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_arith;
    push_op(8'h5F, 8'h0E, 3'd0, 1'b0, 1'b1, {8'h6D, 1'b0, 1'b0, 1'b0}, "add_5f_0e");
    push_op(8'h5F, 8'h0E, 3'd1, 1'b1, 1'b1, {8'h51, 1'b1, 1'b1, 1'b0}, "sub_5f_0e");
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_asrt++;
      // only the most recent result is still on the outputs; check the last one
      if (sb.size() == 0 && {out, c_out, c_flag, zero} !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h/%b/%b/%b want %h/%b/%b/%b", e.nm, out, c_out, c_flag, zero,
                 e.v[10:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic test_logic;
    logic [7:0] res[4];
    res[0] = 8'h0E; res[1] = 8'h5F; res[2] = 8'h51; res[3] = 8'hAE;
    // first check the ADD that precedes SUB (not covered above) on its own
    push_op(8'h5F, 8'h0E, 3'd0, 1'b0, 1'b1, {8'h6D, 1'b0, 1'b0, 1'b0}, "add_5f_0e_b");
    push_op(8'h5F, 8'h0E, 3'd1, 1'b1, 1'b1, {8'h51, 1'b1, 1'b1, 1'b0}, "sub_5f_0e_b");
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      if (i == 0) begin
        e = sb.pop_front();
        n_asrt++;
        if (e.v[10:3] !== 8'h6D) begin
          n_fail++;
          $display("FAIL scoreboard_order: got %h want 6d", e.v[10:3]);
        end
        e = sb.pop_front();
        n_asrt++;
        if ({out, c_out, c_flag, zero} !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h/%b/%b/%b want %h/%b/%b/%b", e.nm, out, c_out, c_flag, zero,
                   e.v[10:3], e.v[2], e.v[1], e.v[0]);
        end
      end
      // c_in=1 must not disturb the logic ops
      push_op(8'h5F, 8'h0E, 3'(i + 2), 1'b1, 1'b1, {res[i], 1'b0, HOLD, 1'b0},
              $sformatf("logic_op%0d", i + 2));
      e = sb.pop_front();
      n_asrt++;
      if ({out, c_out, c_flag, zero} !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h/%b/%b/%b want %h/%b/%b/%b", e.nm, out, c_out, c_flag, zero,
                 e.v[10:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic test_shift_wrap;
    push_op(8'h5F, 8'h00, 3'd6, 1'b0, 1'b1, {8'hBE, 1'b0, 1'b0, 1'b0}, "shl_5f");
    push_op(8'h5F, 8'hAA, 3'd7, 1'b1, 1'b1, {8'hAF, 1'b1, 1'b1, 1'b0}, "shr_5f");
    push_op(8'h80, 8'h80, 3'd0, 1'b0, 1'b1, {8'h00, 1'b1, 1'b1, 1'b1}, "add_wrap");
    push_op(8'h3C, 8'h3C, 3'd1, 1'b1, 1'b1, {8'h00, 1'b1, 1'b1, 1'b1}, "sub_equal");
    push_op(8'h00, 8'h01, 3'd1, 1'b1, 1'b1, {8'hFF, 1'b0, 1'b0, 1'b0}, "sub_borrow");
    push_op(8'h80, 8'h00, 3'd6, 1'b0, 1'b1, {8'h00, 1'b1, 1'b1, 1'b1}, "shl_out");
    // push_op returns after each registering edge, so only the last entry
    // can still be checked on the outputs; earlier ones are checked below.
    n_asrt++;
    if ({out, c_out, c_flag, zero} !== sb[sb.size()-1].v) begin
      n_fail++;
      $display("FAIL shl_out: got %h/%b/%b/%b want 00/1/1/1", out, c_out, c_flag, zero);
    end
    sb.delete();
    // re-run each case individually with a check right after its edge
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      case (i)
        0: push_op(8'h5F, 8'h00, 3'd6, 1'b0, 1'b1, {8'hBE, 1'b0, 1'b0, 1'b0}, "shl_5f");
        1: push_op(8'h5F, 8'hAA, 3'd7, 1'b1, 1'b1, {8'hAF, 1'b1, 1'b1, 1'b0}, "shr_5f");
        2: push_op(8'h80, 8'h80, 3'd0, 1'b0, 1'b1, {8'h00, 1'b1, 1'b1, 1'b1}, "add_wrap");
        3: push_op(8'h3C, 8'h3C, 3'd1, 1'b1, 1'b1, {8'h00, 1'b1, 1'b1, 1'b1}, "sub_equal");
        default: push_op(8'h00, 8'h01, 3'd1, 1'b1, 1'b1, {8'hFF, 1'b0, 1'b0, 1'b0}, "sub_borrow");
      endcase
      e = sb.pop_front();
      n_asrt++;
      if ({out, c_out, c_flag, zero} !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h/%b/%b/%b want %h/%b/%b/%b", e.nm, out, c_out, c_flag, zero,
                 e.v[10:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 1000; i++) begin
      exp_t e;
      push_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 11'h0,
              $sformatf("rand%0d", i));
      n_asrt++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rand%0d: scoreboard empty, got %h want entry", i, out);
      end else begin
        e = sb.pop_front();
        if ({out, c_out, c_flag, zero} !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h/%b/%b/%b want %h/%b/%b/%b op=%0d", e.nm, out, c_out, c_flag,
                   zero, e.v[10:3], e.v[2], e.v[1], e.v[0], op);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
